// File: rtl/pipelined_controller.sv
// Control unit for the 5-stage ARM pipeline: decodes the D-stage instruction,
// carries control through E/M/W, and evaluates condition codes against NZCV.
module pipelined_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  aluflags,
    input  logic        flushe,
    output logic [1:0]  regsrcd,
    output logic [1:0]  immsrcd,
    output logic        alusrce,
    output logic [3:0]  alucontrole,
    output logic [1:0]  shcontrol,
    output logic [4:0]  shamt,
    output logic        branchtakene,
    output logic        blsel,
    output logic        blwritewire,
    output logic        wemwritem,
    output logic        memtoregw,
    output logic        regwritew,
    output logic        pcsrcw,
    output logic        memtorege,
    output logic        regwritem,
    output logic        pcsrcd,
    output logic        pcsrce,
    output logic        pcsrcm
);
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Decode-stage controls
    logic       dec_regwrite, dec_memwrite, dec_memtoreg, dec_branch, dec_bl;
    logic       dec_flagwrite, dec_alusrc, dec_pcsrc;
    logic [3:0] dec_alu;
    logic [1:0] dec_sh, dec_regsrc, dec_immsrc;
    logic [4:0] dec_shamt;

    // Execute-stage register
    logic       e_regwrite_q, e_memwrite_q, e_memtoreg_q, e_branch_q, e_bl_q;
    logic       e_pcsrc_q, e_flagwrite_q, e_alusrc_q;
    logic [3:0] e_alu_q, e_cond_q;
    logic [1:0] e_sh_q;
    logic [4:0] e_shamt_q;
    logic       e_regwrite_d, e_memwrite_d, e_memtoreg_d, e_branch_d, e_bl_d;
    logic       e_pcsrc_d, e_flagwrite_d, e_alusrc_d;
    logic [3:0] e_alu_d, e_cond_d;
    logic [1:0] e_sh_d;
    logic [4:0] e_shamt_d;

    // Flags (NZCV), memory and writeback registers
    logic [3:0] flags_q, flags_d;
    logic       m_regwrite_q, m_memwrite_q, m_memtoreg_q, m_pcsrc_q;
    logic       m_regwrite_d, m_memwrite_d, m_memtoreg_d, m_pcsrc_d;
    logic       w_regwrite_q, w_memtoreg_q, w_pcsrc_q;
    logic       w_regwrite_d, w_memtoreg_d, w_pcsrc_d;
    logic       condexe;
    logic       unused_instr;

    assign unused_instr = ^{instr[19:16], instr[4:0]};

    // Main decoder for the D-stage instruction word
    always_comb begin
        dec_regwrite  = 1'b0;
        dec_memwrite  = 1'b0;
        dec_memtoreg  = 1'b0;
        dec_branch    = 1'b0;
        dec_bl        = 1'b0;
        dec_flagwrite = 1'b0;
        dec_alusrc    = 1'b0;
        dec_alu       = 4'b0000;
        dec_sh        = 2'b00;
        dec_shamt     = 5'd0;
        dec_regsrc    = 2'b00;
        dec_immsrc    = 2'b00;
        case (instr[27:26])
            OP_DP: begin
                dec_regwrite  = (instr[24:23] != 2'b10);
                dec_alu       = instr[24:21];
                dec_flagwrite = instr[20];
                if (instr[25]) begin
                    dec_alusrc = 1'b1;
                    dec_sh     = 2'b11;
                    dec_shamt  = {instr[11:8], 1'b0};
                end else begin
                    dec_sh    = instr[6:5];
                    dec_shamt = instr[11:7];
                end
            end
            OP_MEM: begin
                dec_alusrc = ~instr[25];
                dec_immsrc = 2'b01;
                dec_alu    = instr[23] ? 4'b0100 : 4'b0010;
                if (instr[20]) begin
                    dec_regwrite = 1'b1;
                    dec_memtoreg = 1'b1;
                end else begin
                    dec_memwrite  = 1'b1;
                    dec_regsrc[1] = 1'b1;
                end
            end
            OP_BR: begin
                dec_regsrc[0] = 1'b1;
                dec_immsrc    = 2'b10;
                dec_alusrc    = 1'b1;
                dec_alu       = 4'b0100;
                dec_branch    = 1'b1;
                dec_bl        = instr[24];
            end
            default: ;
        endcase
        dec_pcsrc = dec_regwrite & (instr[15:12] == 4'hF);
    end

    // E-stage next state: a flush inserts a bubble
    always_comb begin
        e_regwrite_d  = dec_regwrite;
        e_memwrite_d  = dec_memwrite;
        e_memtoreg_d  = dec_memtoreg;
        e_branch_d    = dec_branch;
        e_bl_d        = dec_bl;
        e_pcsrc_d     = dec_pcsrc;
        e_flagwrite_d = dec_flagwrite;
        e_alusrc_d    = dec_alusrc;
        e_alu_d       = dec_alu;
        e_sh_d        = dec_sh;
        e_shamt_d     = dec_shamt;
        e_cond_d      = instr[31:28];
        if (flushe) begin
            e_regwrite_d  = 1'b0;
            e_memwrite_d  = 1'b0;
            e_memtoreg_d  = 1'b0;
            e_branch_d    = 1'b0;
            e_bl_d        = 1'b0;
            e_pcsrc_d     = 1'b0;
            e_flagwrite_d = 1'b0;
            e_alusrc_d    = 1'b0;
            e_alu_d       = 4'b0000;
            e_sh_d        = 2'b00;
            e_shamt_d     = 5'd0;
            e_cond_d      = 4'b0000;
        end
    end

    // ARM condition evaluation against the stored NZCV flags
    always_comb begin
        condexe = 1'b0;
        case (e_cond_q)
            4'h0: condexe = flags_q[2];
            4'h1: condexe = ~flags_q[2];
            4'h2: condexe = flags_q[1];
            4'h3: condexe = ~flags_q[1];
            4'h4: condexe = flags_q[3];
            4'h5: condexe = ~flags_q[3];
            4'h6: condexe = flags_q[0];
            4'h7: condexe = ~flags_q[0];
            4'h8: condexe = flags_q[1] & ~flags_q[2];
            4'h9: condexe = ~flags_q[1] | flags_q[2];
            4'hA: condexe = (flags_q[3] == flags_q[0]);
            4'hB: condexe = (flags_q[3] != flags_q[0]);
            4'hC: condexe = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'hD: condexe = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'hE: condexe = 1'b1;
            default: condexe = 1'b0;
        endcase
    end

    // Flags, M and W next state; ALU flag order is {C,V,N,Z}, stored as NZCV
    always_comb begin
        flags_d = flags_q;
        if (e_flagwrite_q && condexe) begin
            flags_d = {aluflags[1], aluflags[0], aluflags[3], aluflags[2]};
        end
        m_regwrite_d = e_regwrite_q & condexe;
        m_memwrite_d = e_memwrite_q & condexe;
        m_memtoreg_d = e_memtoreg_q;
        m_pcsrc_d    = e_pcsrc_q & condexe;
        w_regwrite_d = m_regwrite_q;
        w_memtoreg_d = m_memtoreg_q;
        w_pcsrc_d    = m_pcsrc_q;
    end

    // Pipeline and flag registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            e_regwrite_q  <= 1'b0;
            e_memwrite_q  <= 1'b0;
            e_memtoreg_q  <= 1'b0;
            e_branch_q    <= 1'b0;
            e_bl_q        <= 1'b0;
            e_pcsrc_q     <= 1'b0;
            e_flagwrite_q <= 1'b0;
            e_alusrc_q    <= 1'b0;
            e_alu_q       <= 4'b0000;
            e_sh_q        <= 2'b00;
            e_shamt_q     <= 5'd0;
            e_cond_q      <= 4'b0000;
            flags_q       <= 4'b0000;
            m_regwrite_q  <= 1'b0;
            m_memwrite_q  <= 1'b0;
            m_memtoreg_q  <= 1'b0;
            m_pcsrc_q     <= 1'b0;
            w_regwrite_q  <= 1'b0;
            w_memtoreg_q  <= 1'b0;
            w_pcsrc_q     <= 1'b0;
        end else begin
            e_regwrite_q  <= e_regwrite_d;
            e_memwrite_q  <= e_memwrite_d;
            e_memtoreg_q  <= e_memtoreg_d;
            e_branch_q    <= e_branch_d;
            e_bl_q        <= e_bl_d;
            e_pcsrc_q     <= e_pcsrc_d;
            e_flagwrite_q <= e_flagwrite_d;
            e_alusrc_q    <= e_alusrc_d;
            e_alu_q       <= e_alu_d;
            e_sh_q        <= e_sh_d;
            e_shamt_q     <= e_shamt_d;
            e_cond_q      <= e_cond_d;
            flags_q       <= flags_d;
            m_regwrite_q  <= m_regwrite_d;
            m_memwrite_q  <= m_memwrite_d;
            m_memtoreg_q  <= m_memtoreg_d;
            m_pcsrc_q     <= m_pcsrc_d;
            w_regwrite_q  <= w_regwrite_d;
            w_memtoreg_q  <= w_memtoreg_d;
            w_pcsrc_q     <= w_pcsrc_d;
        end
    end

    assign regsrcd      = dec_regsrc;
    assign immsrcd      = dec_immsrc;
    assign pcsrcd       = dec_pcsrc;
    assign alusrce      = e_alusrc_q;
    assign alucontrole  = e_alu_q;
    assign shcontrol    = e_sh_q;
    assign shamt        = e_shamt_q;
    assign branchtakene = e_branch_q & condexe;
    assign blsel        = e_bl_q & condexe;
    assign blwritewire  = e_bl_q & condexe;
    assign memtorege    = e_memtoreg_q;
    assign pcsrce       = e_pcsrc_q & condexe;
    assign wemwritem    = m_memwrite_q;
    assign regwritem    = m_regwrite_q;
    assign pcsrcm       = m_pcsrc_q;
    assign regwritew    = w_regwrite_q;
    assign memtoregw    = w_memtoreg_q;
    assign pcsrcw       = w_pcsrc_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Scoreboard bench for pipelined_controller: expectations are queued with the
// cycle they are due in and compared on the falling edge of that cycle.
module tb_pipelined_controller;
    logic        clk, reset, flushe;
    logic [31:0] instr;
    logic [3:0]  aluflags;
    logic [1:0]  regsrcd, immsrcd, shcontrol;
    logic        alusrce, branchtakene, blsel, blwritewire, wemwritem;
    logic [3:0]  alucontrole;
    logic [4:0]  shamt;
    logic        memtoregw, regwritew, pcsrcw, memtorege, regwritem;
    logic        pcsrcd, pcsrce, pcsrcm;

    pipelined_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .aluflags(aluflags), .flushe(flushe),
        .regsrcd(regsrcd), .immsrcd(immsrcd), .alusrce(alusrce), .alucontrole(alucontrole),
        .shcontrol(shcontrol), .shamt(shamt), .branchtakene(branchtakene), .blsel(blsel),
        .blwritewire(blwritewire), .wemwritem(wemwritem), .memtoregw(memtoregw),
        .regwritew(regwritew), .pcsrcw(pcsrcw), .memtorege(memtorege), .regwritem(regwritem),
        .pcsrcd(pcsrcd), .pcsrce(pcsrce), .pcsrcm(pcsrcm)
    );

    localparam int S_ALL = 0, S_REGSRCD = 1, S_IMMSRCD = 2, S_ALUSRCE = 3, S_ALUCTL = 4;
    localparam int S_SH = 5, S_SHAMT = 6, S_BRT = 7, S_BLSEL = 8, S_BLWW = 9, S_WEM = 10;
    localparam int S_MTRW = 11, S_RWW = 12, S_PCW = 13, S_MTRE = 14, S_RWM = 15;
    localparam int S_PCD = 16, S_PCE = 17, S_PCM = 18;

    localparam logic [31:0] I_ADDS   = 32'hE2921005;
    localparam logic [31:0] I_ADDROT = 32'hE2821405;
    localparam logic [31:0] I_ADDLSR = 32'hE08211A3;
    localparam logic [31:0] I_SUBS   = 32'hE2522001;
    localparam logic [31:0] I_BEQ    = 32'h0A000002;
    localparam logic [31:0] I_BNE    = 32'h1A000002;
    localparam logic [31:0] I_BCS    = 32'h2A000002;
    localparam logic [31:0] I_NEVER  = 32'hF2921005;
    localparam logic [31:0] I_STR    = 32'hE5843008;
    localparam logic [31:0] I_LDR    = 32'hE5943008;
    localparam logic [31:0] I_LDRSUB = 32'hE5143008;
    localparam logic [31:0] I_BL     = 32'hEB000004;
    localparam logic [31:0] I_MOVPC  = 32'hE1A0F00E;
    localparam logic [31:0] I_CMP    = 32'hE3520000;
    localparam logic [31:0] I_NOP    = 32'h0C000000;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t keep[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            S_ALL: obs = 32'({regsrcd, immsrcd, alusrce, alucontrole, shcontrol, shamt,
                              branchtakene, blsel, blwritewire, wemwritem, memtoregw,
                              regwritew, pcsrcw, memtorege, regwritem, pcsrcd, pcsrce, pcsrcm});
            S_REGSRCD: obs = 32'(regsrcd);
            S_IMMSRCD: obs = 32'(immsrcd);
            S_ALUSRCE: obs = 32'(alusrce);
            S_ALUCTL:  obs = 32'(alucontrole);
            S_SH:      obs = 32'(shcontrol);
            S_SHAMT:   obs = 32'(shamt);
            S_BRT:     obs = 32'(branchtakene);
            S_BLSEL:   obs = 32'(blsel);
            S_BLWW:    obs = 32'(blwritewire);
            S_WEM:     obs = 32'(wemwritem);
            S_MTRW:    obs = 32'(memtoregw);
            S_RWW:     obs = 32'(regwritew);
            S_PCW:     obs = 32'(pcsrcw);
            S_MTRE:    obs = 32'(memtorege);
            S_RWM:     obs = 32'(regwritem);
            S_PCD:     obs = 32'(pcsrcd);
            S_PCE:     obs = 32'(pcsrce);
            S_PCM:     obs = 32'(pcsrcm);
            default:   obs = 32'hDEADBEEF;
        endcase
    endfunction

    // Compare every expectation due in the current cycle, away from the active edge
    always @(negedge clk) begin
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) check_eq(sb[i].tag, obs(sb[i].sig), sb[i].val);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    end

    // Queue an expectation dc cycles after the instruction now in D
    task automatic sb_push(input int dc, input int sig, input logic [31:0] val, input string tag);
        exp_t e;
        e.cyc = cyc + dc;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] i, input logic [3:0] f, input logic fl);
        instr    = i;
        aluflags = f;
        flushe   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) drive(I_NOP, 4'b0000, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        instr    = I_ADDS;
        aluflags = 4'b0000;
        flushe   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, then ADDS R1,R2,#5
        sb_push(0, S_ALL, 32'h0, "reset_all_zero");
        sb_push(0, S_IMMSRCD, 32'd0, "adds_immsrcd");
        sb_push(1, S_ALUSRCE, 32'd1, "adds_alusrce");
        sb_push(1, S_ALUCTL, 32'd4, "adds_aluctl");
        sb_push(1, S_SH, 32'd3, "adds_sh");
        sb_push(1, S_SHAMT, 32'd0, "adds_shamt");
        sb_push(2, S_RWM, 32'd1, "adds_regwritem");
        sb_push(3, S_RWW, 32'd1, "adds_regwritew");
        sb_push(3, S_PCW, 32'd0, "adds_pcsrcw");
        drive(I_ADDS, 4'b0000, 1'b0);
        sb_push(1, S_SHAMT, 32'd8, "addrot_shamt");
        sb_push(1, S_SH, 32'd3, "addrot_sh");
        drive(I_ADDROT, 4'b0000, 1'b0);
        sb_push(1, S_SHAMT, 32'd3, "addlsr_shamt");
        sb_push(1, S_SH, 32'd1, "addlsr_sh");
        sb_push(1, S_ALUSRCE, 32'd0, "addlsr_alusrce");
        drive(I_ADDLSR, 4'b0000, 1'b0);
        drain(3);

        // SUBS sets Z, BEQ taken
        sb_push(3, S_RWW, 32'd1, "subs_regwritew");
        sb_push(2, S_BRT, 32'd1, "beq_taken");
        sb_push(1, S_REGSRCD, 32'd1, "beq_regsrcd");
        sb_push(1, S_IMMSRCD, 32'd2, "beq_immsrcd");
        drive(I_SUBS, 4'b0000, 1'b0);
        drive(I_BEQ, 4'b0001, 1'b0);
        drain(3);

        // SUBS sets Z, BNE not taken
        sb_push(2, S_BRT, 32'd0, "bne_not_taken");
        drive(I_SUBS, 4'b0000, 1'b0);
        drive(I_BNE, 4'b0001, 1'b0);
        drain(3);

        // SUBS clears Z; flags present during BNE's own E cycle must not bypass
        sb_push(2, S_BRT, 32'd1, "bne_taken_nobypass");
        drive(I_SUBS, 4'b0000, 1'b0);
        drive(I_BNE, 4'b0000, 1'b0);
        drive(I_NOP, 4'b0001, 1'b0);
        drain(2);

        // Carry mapping: C arrives on aluflags[3]
        sb_push(2, S_BRT, 32'd1, "bcs_taken");
        drive(I_SUBS, 4'b0000, 1'b0);
        drive(I_BCS, 4'b1000, 1'b0);
        drain(3);

        // Condition NEVER: no register write and no flag update
        sb_push(1, S_ALUCTL, 32'd4, "never_aluctl");
        sb_push(2, S_RWM, 32'd0, "never_regwritem");
        sb_push(3, S_RWW, 32'd0, "never_regwritew");
        sb_push(2, S_BRT, 32'd0, "never_noflags_beq");
        drive(I_NEVER, 4'b0000, 1'b0);
        drive(I_BEQ, 4'b0001, 1'b0);
        drain(3);

        // STR
        sb_push(0, S_REGSRCD, 32'd2, "str_regsrcd");
        sb_push(0, S_IMMSRCD, 32'd1, "str_immsrcd");
        sb_push(1, S_ALUSRCE, 32'd1, "str_alusrce");
        sb_push(1, S_ALUCTL, 32'd4, "str_aluctl");
        sb_push(2, S_WEM, 32'd1, "str_wemwritem");
        sb_push(2, S_RWM, 32'd0, "str_regwritem");
        sb_push(3, S_RWW, 32'd0, "str_regwritew");
        drive(I_STR, 4'b0000, 1'b0);
        // LDR, then LDR with U=0
        sb_push(0, S_REGSRCD, 32'd0, "ldr_regsrcd");
        sb_push(1, S_MTRE, 32'd1, "ldr_memtorege");
        sb_push(2, S_WEM, 32'd0, "ldr_wemwritem");
        sb_push(3, S_MTRW, 32'd1, "ldr_memtoregw");
        sb_push(3, S_RWW, 32'd1, "ldr_regwritew");
        drive(I_LDR, 4'b0000, 1'b0);
        sb_push(1, S_ALUCTL, 32'd2, "ldrsub_aluctl");
        drive(I_LDRSUB, 4'b0000, 1'b0);
        drain(3);

        // BL
        sb_push(0, S_REGSRCD, 32'd1, "bl_regsrcd");
        sb_push(1, S_BRT, 32'd1, "bl_branchtaken");
        sb_push(1, S_BLSEL, 32'd1, "bl_blsel");
        sb_push(1, S_BLWW, 32'd1, "bl_blwritewire");
        sb_push(2, S_RWM, 32'd0, "bl_regwritem");
        drive(I_BL, 4'b0000, 1'b0);
        drain(3);

        // BL and ADDS flushed at the D->E edge
        sb_push(1, S_BRT, 32'd0, "blflush_branchtaken");
        sb_push(1, S_BLSEL, 32'd0, "blflush_blsel");
        sb_push(1, S_BLWW, 32'd0, "blflush_blwritewire");
        drive(I_BL, 4'b0000, 1'b1);
        sb_push(1, S_ALL, 32'h0, "addsflush_e_zero");
        sb_push(2, S_RWM, 32'd0, "addsflush_regwritem");
        sb_push(3, S_RWW, 32'd0, "addsflush_regwritew");
        drive(I_ADDS, 4'b0000, 1'b1);
        drain(3);

        // Write to R15, then CMP (no register write)
        sb_push(0, S_PCD, 32'd1, "movpc_pcsrcd");
        sb_push(1, S_PCE, 32'd1, "movpc_pcsrce");
        sb_push(2, S_PCM, 32'd1, "movpc_pcsrcm");
        sb_push(3, S_PCW, 32'd1, "movpc_pcsrcw");
        drive(I_MOVPC, 4'b0000, 1'b0);
        sb_push(2, S_RWM, 32'd0, "cmp_regwritem");
        sb_push(3, S_RWW, 32'd0, "cmp_regwritew");
        drive(I_CMP, 4'b0000, 1'b0);
        drain(3);

        // Reset mid-flight kills the in-flight write and clears flags (Z set first)
        sb_push(3, S_RWW, 32'd0, "midreset_regwritew");
        sb_push(4, S_BRT, 32'd0, "midreset_flags_clear");
        drive(I_SUBS, 4'b0000, 1'b0);
        drive(I_NOP, 4'b0001, 1'b0);
        reset = 1'b1;
        drive(I_NOP, 4'b0000, 1'b0);
        reset = 1'b0;
        drive(I_BEQ, 4'b0000, 1'b0);
        drain(4);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
